clk_div_prog_duty50: RTL

- Runtime-programmable integer clock divider producing a 50%-duty output for both even and odd divisors.
- Successor to the fixed divide-by-15 odd divider, generalised in three ways:
  - parametrised counter width;
  - divisor loadable at run time and applied glitch-free only at period boundaries;
  - enable with clean start/stop, plus a single-cycle tick strobe for logic in the clk_in domain.
- Sits in the clock-generation area and feeds slow peripheral clocks and enables.

---
 rtl/clk_div_prog_duty50.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clk_div_prog_duty50.sv
`timescale 1ns/1ps
// Runtime-programmable integer clock divider with 50% duty for even and odd divisors.
// A falling-edge retime of the rising-edge phase trims half a cycle off odd-N high phases.
module clk_div_prog_duty50 #(
   parameter int WIDTH       = 8,
   parameter int DIV_DEFAULT = 15
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_cur,
   output logic             err
);

   localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_DEFAULT);
   localparam logic [WIDTH-1:0] DIV_MIN  = WIDTH'(2);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             clk_p_q, clk_p_d;
   logic             clk_n_q, clk_n_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             odd_q, odd_d;

   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] last_cnt;
   logic [WIDTH:0]   hi_cnt;
   logic             apply;

   always_comb begin
      pend_d  = pend_q;
      err_d   = 1'b0;
      if (load) begin
         if (div_val < DIV_MIN) begin
            pend_d = DIV_MIN;
            err_d  = 1'b1;
         end else begin
            pend_d = div_val;
         end
      end

      hi_cnt   = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
      last_cnt = div_q - WIDTH'(1);
      cnt_inc  = cnt_q + WIDTH'(1);

      state_d = state_q;
      cnt_d   = cnt_q;
      clk_p_d = clk_p_q;
      tick_d  = 1'b0;
      apply   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            clk_p_d = 1'b0;
            apply   = 1'b1;
            if (en) begin
               state_d = ST_RUN;
               clk_p_d = 1'b1;
               tick_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == last_cnt) begin
               cnt_d = '0;
               if (en) begin
                  // New divisor lands exactly where clk_p rises and clk_n is still low.
                  clk_p_d = 1'b1;
                  tick_d  = 1'b1;
                  apply   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  clk_p_d = 1'b0;
               end
            end else begin
               cnt_d   = cnt_inc;
               clk_p_d = ({1'b0, cnt_inc} < hi_cnt);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clk_p_d = 1'b0;
         end
      endcase

      div_d   = apply ? pend_d : div_q;
      odd_d   = apply ? pend_d[0] : odd_q;
      clk_n_d = rst ? 1'b0 : clk_p_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         clk_p_q <= 1'b0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
         div_q   <= DIV_INIT;
         pend_q  <= DIV_INIT;
         odd_q   <= DIV_INIT[0];
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clk_p_q <= clk_p_d;
         tick_q  <= tick_d;
         err_q   <= err_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         odd_q   <= odd_d;
      end
   end

   always_ff @(negedge clk_in) begin
      clk_n_q <= clk_n_d;
   end

   assign clk_out = odd_q ? (clk_p_q & clk_n_q) : clk_p_q;
   assign tick    = tick_q;
   assign div_cur = div_q;
   assign err     = err_q;

endmodule
